// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file writeback definitions: data width, register index
// width, the hardwired-zero register and the requester grant encoding.
package rv_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: req[0]=ALU, req[1]=LSU. Grants are
// combinational; the last winner is remembered so ties alternate.
module rr_arb2
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_e last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (last_grant == GNT_LSU) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Reset to LSU so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= GNT_LSU;
    else if (gnt[0]) last_grant <= GNT_ALU;
    else if (gnt[1]) last_grant <= GNT_LSU;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Sole owner of the register file write port: clears x1..x(NREG-1) after
// reset, then arbitrates ALU/LSU writebacks onto registered we/rd/wd.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN           = rv_pkg::XLEN,
  parameter int NREG           = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_wd,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_wd,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_wd
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [REG_IDX_W-1:0] LAST_REG = REG_IDX_W'(NREG - 1);
  localparam state_e ST_RST   = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic   DONE_RST = (CLEAR_ON_RESET == 0);

  state_e                 state, state_nxt;
  logic [REG_IDX_W-1:0]   cnt;
  logic [1:0]             gnt;
  logic [REG_IDX_W-1:0]   sel_rd;
  logic [XLEN-1:0]        sel_wd;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_RUN),
    .req   ({lsu_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign sel_rd    = gnt[1] ? lsu_rd : alu_rd;
  assign sel_wd    = gnt[1] ? lsu_wd : alu_wd;

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && cnt == LAST_REG) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wd     <= '0;
      cnt       <= REG_IDX_W'(1);
      init_done <= DONE_RST;
    end else begin
      rf_we     <= 1'b0;
      init_done <= (state == ST_RUN);
      if (state == ST_INIT) begin
        rf_we <= 1'b1;
        rf_rd <= cnt;
        rf_wd <= '0;
        // Counter parks at the last register rather than wrapping to x0.
        if (cnt != LAST_REG) cnt <= cnt + 1'b1;
      end else if (|gnt) begin
        // Writes to x0 are consumed but never reach the array.
        rf_we <= (sel_rd != REG_ZERO);
        rf_rd <= sel_rd;
        rf_wd <= sel_wd;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: clear sequence, async reset mid-clear, a vector
// table of handshakes and a randomized run against a reference model.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init_done;
  logic            alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_wd, lsu_wd;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .NREG(32), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  // Register file fed by the DUT write port; x0 is stored too so stray
  // writes to it are visible.
  logic [XLEN-1:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_rd] <= rf_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
  endtask

  // Issue n clear edges with both requesters knocking; full run checks init_done.
  task automatic run_init(input int n);
    for (int i = 1; i <= n; i++) begin
      drive(1'b1, 5'd3, 32'hABCD, 1'b1, 5'd4, 32'h1234);
      #1;
      chk("init_alu_ready", alu_ready, 0);
      chk("init_lsu_ready", lsu_ready, 0);
      chk("init_done_low", init_done, 0);
      step();
      chk("init_we", rf_we, 1);
      chk("init_rd", rf_rd, i);
      chk("init_wd", rf_wd, 0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    if (n == 31) begin
      step();
      chk("init_done_high", init_done, 1);
      chk("init_we_off", rf_we, 0);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_init_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] awd;
    logic lv; logic [4:0] lrd; logic [31:0] lwd;
    logic e_ar; logic e_lr; logic e_we; logic [4:0] e_rd; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl [16];

  logic [31:0] exp_mem [32];

  initial begin
    // Table starts right after a clear: last winner is LSU, rf_rd=31, rf_wd=0.
    tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 1, 5'd5,  32'hDEADBEEF};
    tbl[1]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd5,  32'hDEADBEEF};
    tbl[2]  = '{1, 5'd1,  32'h11,       1, 5'd2,  32'h22,       0, 1, 1, 5'd2,  32'h22};
    tbl[3]  = '{1, 5'd1,  32'h11,       1, 5'd3,  32'h33,       1, 0, 1, 5'd1,  32'h11};
    tbl[4]  = '{1, 5'd4,  32'h44,       1, 5'd3,  32'h33,       0, 1, 1, 5'd3,  32'h33};
    tbl[5]  = '{1, 5'd4,  32'h44,       0, 5'd0,  32'h0,        1, 0, 1, 5'd4,  32'h44};
    tbl[6]  = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h12345678, 0, 1, 0, 5'd0,  32'h12345678};
    tbl[7]  = '{1, 5'd7,  32'h1,        1, 5'd7,  32'h2,        1, 0, 1, 5'd7,  32'h1};
    tbl[8]  = '{0, 5'd0,  32'h0,        1, 5'd7,  32'h2,        0, 1, 1, 5'd7,  32'h2};
    tbl[9]  = '{1, 5'd0,  32'hAAAA,     0, 5'd0,  32'h0,        1, 0, 0, 5'd0,  32'hAAAA};
    tbl[10] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd0,  32'hAAAA};
    tbl[11] = '{0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 1, 1, 5'd9,  32'h99};
    tbl[12] = '{1, 5'd10, 32'hA0,       1, 5'd11, 32'hB1,       1, 0, 1, 5'd10, 32'hA0};
    tbl[13] = '{1, 5'd12, 32'hA2,       1, 5'd11, 32'hB1,       0, 1, 1, 5'd11, 32'hB1};
    tbl[14] = '{1, 5'd12, 32'hA2,       1, 5'd13, 32'hB3,       1, 0, 1, 5'd12, 32'hA2};
    tbl[15] = '{1, 5'd14, 32'hA4,       1, 5'd13, 32'hB3,       0, 1, 1, 5'd13, 32'hB3};

    rf_mem[0] = '0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    do_reset();

    // Partial clear up to cnt=17, then yank reset and restart from x1.
    run_init(16);
    do_reset();
    run_init(31);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].awd, tbl[i].lv, tbl[i].lrd, tbl[i].lwd);
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("v%0d_lsu_ready", i), lsu_ready, tbl[i].e_lr);
      step();
      chk($sformatf("v%0d_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("v%0d_rd", i), rf_rd, tbl[i].e_rd);
      chk($sformatf("v%0d_wd", i), rf_wd, tbl[i].e_wd);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("x5", rf_mem[5], 32'hDEADBEEF);
    chk("x7_last_grant_wins", rf_mem[7], 32'h2);
    chk("x0", rf_mem[0], 32'h0);
    chk("x2", rf_mem[2], 32'h22);
    chk("x12", rf_mem[12], 32'hA2);
    chk("x13", rf_mem[13], 32'hB3);
    chk("x20_cleared", rf_mem[20], 32'h0);

    // Randomized run; model tracks pending requests, last winner and the array.
    do_reset();
    run_init(31);
    begin
      logic ap = 0, lp = 0;
      logic [4:0] ard = 0, lrd = 0, e_rd = 5'd31;
      logic [31:0] awd = 0, lwd = 0, e_wd = 0;
      logic e_we;
      int last = 1;  // 0=ALU, 1=LSU
      int w;
      for (int r = 0; r < 32; r++) exp_mem[r] = '0;
      for (int c = 0; c < 400; c++) begin
        if (!ap && $urandom_range(1, 0) == 1) begin
          ap = 1; ard = 5'($urandom_range(31, 0)); awd = $urandom;
        end
        if (!lp && $urandom_range(1, 0) == 1) begin
          lp = 1; lrd = 5'($urandom_range(31, 0)); lwd = $urandom;
        end
        drive(ap, ard, awd, lp, lrd, lwd);
        if (ap && lp) w = 1 - last;
        else if (ap)  w = 0;
        else if (lp)  w = 1;
        else          w = -1;
        #1;
        chk("rnd_alu_ready", alu_ready, (w == 0));
        chk("rnd_lsu_ready", lsu_ready, (w == 1));
        step();
        e_we = 0;
        if (w == 0) begin
          e_we = (ard != 0); e_rd = ard; e_wd = awd; ap = 0; last = 0;
          if (ard != 0) exp_mem[ard] = awd;
        end else if (w == 1) begin
          e_we = (lrd != 0); e_rd = lrd; e_wd = lwd; lp = 0; last = 1;
          if (lrd != 0) exp_mem[lrd] = lwd;
        end
        chk("rnd_we", rf_we, e_we);
        chk("rnd_rd", rf_rd, e_rd);
        chk("rnd_wd", rf_wd, e_wd);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    for (int r = 0; r < 32; r++) chk($sformatf("rnd_x%0d", r), rf_mem[r], exp_mem[r]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Single-owner controller for the register file's one write port (we/rd/wd).
- After reset, clears x1..x31 to zero, because the register array has no reset.
- Then arbitrates round-robin between two writeback requesters, ALU and load/store unit, using valid/ready handshakes.
- Sits between the execute/memory stages and the register file. It drives rf_we/rf_rd/rf_wd from registers.

Parameters:
- XLEN, 32, data width of write data.
- NREG, 32, number of architectural registers; index width is 5.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go directly to RUN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- init_done  out  1  high once the clear sequence completes; stays high until the next reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_wd  in  XLEN  ALU result.
- lsu_valid  in  1  load writeback request.
- lsu_ready  out  1  load request accepted this cycle.
- lsu_rd  in  5  load destination register.
- lsu_wd  in  XLEN  load data.
- rf_we  out  1  register file write enable (registered).
- rf_rd  out  5  register file write index (registered).
- rf_wd  out  XLEN  register file write data (registered).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named rst_n.
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, init_done=0, clear counter=1, last_grant=LSU (so ALU wins the first tie). State = INIT if CLEAR_ON_RESET=1, else RUN with init_done=1.
- States: INIT and RUN.
- INIT, one clear write per cycle:
  - Each rising edge registers rf_we=1, rf_rd=cnt, rf_wd=0, then cnt+1.
  - cnt runs 1..31 and never wraps; 31 writes total.
  - On the edge that issues cnt=31, the next state is RUN.
  - init_done rises on the following edge (32nd edge after reset release); rf_we=0 on that same edge unless a grant occurs.
- INIT handshake: alu_ready=lsu_ready=0 throughout; requester valid/data are ignored.
- RUN, ready generation (combinational from valids and last_grant):
  - Only alu_valid: alu_ready=1.
  - Only lsu_valid: lsu_ready=1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: both readies 0.
  - Never both readies high in one cycle.
- RUN, acceptance (valid & ready at a rising edge):
  - Registers rf_we=(rd!=0), rf_rd=rd, rf_wd=wd, and updates last_grant to the winner.
  - A request to x0 is accepted and consumed but produces rf_we=0.
  - No acceptance: rf_we=0; rf_rd/rf_wd hold their previous values.
- Latency: acceptance edge N → rf_we high after edge N → the register file captures at edge N+1. The read ports show the new value after edge N+1. Forwarding of in-flight writes is the pipeline's responsibility.
- Requester contract: valid must stay high and rd/wd stable until ready. The arbiter does not buffer; an ungranted requester simply waits.
- Fairness: with both requesters continuously valid, grants alternate ALU, LSU, ALU, ... Maximum wait is 1 cycle.
- Same-rd collision: both requesters targeting the same rd are serialized in grant order. The later grant wins in the register file.
- Reset mid-INIT or mid-RUN: all state returns to reset values immediately. The clear sequence restarts at x1, and any in-flight registered write is dropped (rf_we=0 asynchronously).
- Width rules: the counter is 5 bits; XLEN data passes through unmodified.

Decomposition:
- Shared package rv_pkg: XLEN, REG_IDX_W=5, REG_ZERO=5'd0, and a grant enum {GNT_ALU, GNT_LSU}. The FSM state enum {ST_INIT, ST_RUN} stays local.
- One natural sub-module: rr_arb2, a two-input round-robin arbiter (req[1:0], last_grant → gnt[1:0]), combinational plus pointer update. The FSM and output registers stay in the top.

Test Plan:
- Reset release, no requests, CLEAR_ON_RESET=1:
  - Expect 31 consecutive rf_we=1 cycles with rf_rd=1..31 and rf_wd=0.
  - init_done=1 on edge 32; readies stay 0 throughout INIT.
- After init, alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF for one cycle:
  - alu_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF.
  - A read of x5 returns 0xDEADBEEF after the following edge.
- ALU and LSU both held valid for 4 cycles, with distinct rd:
  - Grants go ALU, LSU, ALU, LSU; exactly one ready per cycle.
  - rf_rd sequence matches the grant order.
- lsu_valid=1, lsu_rd=0, lsu_wd=0x12345678:
  - lsu_ready=1, rf_we=0 the next cycle; x0 reads 0 afterwards.
- rst_n pulsed low while cnt=17 in INIT:
  - rf_we falls immediately.
  - After release, clearing restarts at rf_rd=1 and init_done rises after 32 edges.
- Both requesters target rd=7 (ALU 0x1, LSU 0x2) simultaneously:
  - ALU is written first, then LSU; the final x7 value is 0x2.
